stage_execute: RTL

STAGE_EXECUTE -- requirements
Module: stage_execute

---
 rtl/stage_execute.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/stage_execute.sv
// Execute stage: operand select, ALU, branch/jump target, and a fixed-latency
// multiply sequencer feeding a registered hand-off to the memory stage.
module stage_execute #(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_rdata1,
  input  logic [31:0] ex_rdata2,
  input  logic [31:0] ex_imm,
  input  logic        ex_use_pc0,
  input  logic        ex_use_pc1,
  input  logic        ex_use_imm,
  input  logic        ex_sub_sra,
  input  logic [3:0]  ex_op,
  input  logic [7:0]  ex_memctl,
  input  logic [4:0]  ex_wreg,
  input  logic        mem_stall,
  output logic        ex_stall,
  output logic [31:0] ex_forward_data,
  output logic        mem_valid,
  output logic [31:0] mem_result,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_target,
  output logic [7:0]  mem_ctl,
  output logic [4:0]  mem_wreg
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned CNTW = 4;
  localparam int unsigned JMP_BIT = 2;

  localparam logic [3:0] ALUOP_ADD    = 4'd0;
  localparam logic [3:0] ALUOP_SL     = 4'd1;
  localparam logic [3:0] ALUOP_SR     = 4'd2;
  localparam logic [3:0] ALUOP_SLT    = 4'd3;
  localparam logic [3:0] ALUOP_SLTU   = 4'd4;
  localparam logic [3:0] ALUOP_SEQ    = 4'd5;
  localparam logic [3:0] ALUOP_XOR    = 4'd6;
  localparam logic [3:0] ALUOP_OR     = 4'd7;
  localparam logic [3:0] ALUOP_AND    = 4'd8;
  localparam logic [3:0] ALUOP_NOP    = 4'd9;
  localparam logic [3:0] ALUOP_MUL    = 4'd10;
  localparam logic [3:0] ALUOP_MULH   = 4'd11;
  localparam logic [3:0] ALUOP_MULHSU = 4'd12;
  localparam logic [3:0] ALUOP_MULHU  = 4'd13;

  typedef enum logic [0:0] {ST_IDLE, ST_BUSY} state_t;

  state_t            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              mul_stall;
  logic              is_mul;

  logic [XLEN-1:0]   op_a, op_b, result, target;
  logic [4:0]        shamt;
  logic [63:0]       prod_u;
  logic [XLEN-1:0]   hi_uu, hi_su, hi_ss;

  logic              valid_q;
  logic [XLEN-1:0]   result_q, wdata_q, target_q;
  logic [7:0]        ctl_q;
  logic [4:0]        wreg_q;

  // Operand selection and shared datapath terms
  always_comb begin
    op_a   = ex_use_pc0 ? ex_pc : ex_rdata1;
    op_b   = ex_use_imm ? ex_imm : ex_rdata2;
    shamt  = op_b[4:0];
    is_mul = (ex_op >= ALUOP_MUL) && (ex_op <= ALUOP_MULHU);
    target = ((ex_use_pc1 ? ex_pc : ex_rdata1) + ex_imm) & ~XLEN'(1);
  end

  // Signed high halves derived from one unsigned product by subtracting the
  // two's-complement correction terms modulo 2^32.
  always_comb begin
    prod_u = 64'(op_a) * 64'(op_b);
    hi_uu  = prod_u[63:32];
    hi_su  = hi_uu - (op_a[31] ? op_b : '0);
    hi_ss  = hi_su - (op_b[31] ? op_a : '0);
  end

  // ALU result; jumps override with the link address
  always_comb begin
    result = '0;
    case (ex_op)
      ALUOP_ADD:    result = ex_sub_sra ? (op_a - op_b) : (op_a + op_b);
      ALUOP_SL:     result = op_a << shamt;
      ALUOP_SR:     result = ex_sub_sra ? XLEN'($signed(op_a) >>> shamt) : (op_a >> shamt);
      ALUOP_SLT:    result = {31'd0, $signed(op_a) < $signed(op_b)};
      ALUOP_SLTU:   result = {31'd0, op_a < op_b};
      ALUOP_SEQ:    result = {31'd0, op_a == op_b};
      ALUOP_XOR:    result = op_a ^ op_b;
      ALUOP_OR:     result = op_a | op_b;
      ALUOP_AND:    result = op_a & op_b;
      ALUOP_NOP:    result = op_b;
      ALUOP_MUL:    result = prod_u[31:0];
      ALUOP_MULH:   result = hi_ss;
      ALUOP_MULHSU: result = hi_su;
      ALUOP_MULHU:  result = hi_uu;
      default:      result = '0;
    endcase
    if (ex_memctl[JMP_BIT]) result = ex_pc + XLEN'(4);
  end

  // Multiply sequencer next-state; frozen while the memory stage stalls
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mul_stall = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ex_valid && is_mul) begin
          mul_stall = 1'b1;
          if (!mem_stall) begin
            state_d = ST_BUSY;
            cnt_d   = CNTW'(MUL_LAT - 1);
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q != '0) begin
          mul_stall = 1'b1;
          if (!mem_stall) cnt_d = cnt_q - CNTW'(1);
        end else if (!mem_stall) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Memory-stage hand-off; a multiply in progress inserts bubbles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      wdata_q  <= '0;
      target_q <= '0;
      ctl_q    <= '0;
      wreg_q   <= '0;
    end else if (!mem_stall) begin
      if (mul_stall) begin
        valid_q <= 1'b0;
      end else begin
        valid_q  <= ex_valid;
        result_q <= result;
        wdata_q  <= ex_rdata2;
        target_q <= target;
        ctl_q    <= ex_memctl;
        wreg_q   <= ex_wreg;
      end
    end
  end

  assign ex_stall        = mem_stall | mul_stall;
  assign ex_forward_data = result;
  assign mem_valid       = valid_q;
  assign mem_result      = result_q;
  assign mem_wdata       = wdata_q;
  assign mem_target      = target_q;
  assign mem_ctl         = ctl_q;
  assign mem_wreg        = wreg_q;

endmodule
